// File: rtl/imem_loader_pkg.sv
// Shared definitions for the byte-stream instruction-memory loader.
// The loader and the CPU datapath both take their power-up start address from here.
package imem_loader_pkg;

    typedef enum logic [3:0] {
        S_SYNC,
        S_ADDR_H,
        S_ADDR_L,
        S_LEN_H,
        S_LEN_L,
        S_VALIDATE,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [7:0]  SYNC_BYTE  = 8'hA5;
    localparam logic [15:0] DEFAULT_PC = 16'd10;

endpackage

// File: rtl/imem_loader_frame_checksum.sv
// Running 8-bit modulo-256 sum over the bytes of one frame.
// A clear wins over a simultaneous add, so a new frame always starts from zero.
module frame_checksum (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_clear,
    input  logic       i_add_en,
    input  logic [7:0] i_byte,
    output logic [7:0] o_sum
);

    logic [7:0] r_sum;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_sum <= 8'd0;
        end else if (i_clear) begin
            r_sum <= 8'd0;
        end else if (i_add_en) begin
            r_sum <= r_sum + i_byte;
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/imem_loader.sv
// Receives framed program images over a valid/ready byte stream, writes them into the
// big-endian instruction memory and releases the CPU once the frame checksum verifies.
//   state    | meaning
//   SYNC     | hunting for A5; other bytes dropped
//   ADDR_H/L | latching load address
//   LEN_H/L  | latching payload length
//   VALIDATE | one stalled cycle checking addr/len legality
//   DATA     | writing payload bytes to memory
//   CSUM     | comparing trailing checksum byte
//   DONE     | image good, CPU running from StartPC
//   ERROR    | frame rejected, CPU held
module imem_loader #(
    parameter int          MEM_BYTES  = 128,
    parameter logic [15:0] DEFAULT_PC = imem_loader_pkg::DEFAULT_PC
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_in_valid,
    input  logic [7:0]  i_in_byte,
    output logic        o_in_ready,
    output logic        o_mem_write,
    output logic [15:0] o_mem_address,
    output logic [7:0]  o_mem_data,
    output logic        o_cpu_hold,
    output logic [15:0] o_start_pc,
    output logic        o_done,
    output logic        o_error
);

    import imem_loader_pkg::*;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_in_ready;
    logic        r_mem_write;
    logic [15:0] r_mem_address;
    logic [7:0]  r_mem_data;
    logic        r_cpu_hold;
    logic [15:0] r_start_pc;
    logic        r_done;
    logic        r_error;
    logic [15:0] r_addr;
    logic [15:0] r_len;
    logic [15:0] r_wr_ptr;
    logic [15:0] r_remaining;

    logic        w_accept;
    logic        w_is_sync;
    logic [16:0] w_end;
    logic        w_bad_frame;
    logic        w_cs_clear;
    logic        w_cs_add;
    logic [7:0]  w_sum;
    logic        w_csum_ok;

    assign w_accept    = i_in_valid & r_in_ready;
    assign w_is_sync   = (i_in_byte == SYNC_BYTE);
    // 17-bit end address so a frame near 0xFFFF cannot wrap back into range
    assign w_end       = {1'b0, r_addr} + {1'b0, r_len};
    assign w_bad_frame = (r_len == 16'd0) | r_len[0] | r_addr[0] | (w_end > 17'(MEM_BYTES));
    assign w_csum_ok   = (i_in_byte == w_sum);

    frame_checksum u_checksum (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_clear  (w_cs_clear),
        .i_add_en (w_cs_add),
        .i_byte   (i_in_byte),
        .o_sum    (w_sum)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_SYNC;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cs_clear   = 1'b0;
        w_cs_add     = 1'b0;
        case (r_state)
            S_SYNC, S_DONE, S_ERROR: begin
                if (w_accept && w_is_sync) begin
                    w_next_state = S_ADDR_H;
                    w_cs_clear   = 1'b1;
                end
            end
            S_ADDR_H: begin
                if (w_accept) begin
                    w_next_state = S_ADDR_L;
                    w_cs_add     = 1'b1;
                end
            end
            S_ADDR_L: begin
                if (w_accept) begin
                    w_next_state = S_LEN_H;
                    w_cs_add     = 1'b1;
                end
            end
            S_LEN_H: begin
                if (w_accept) begin
                    w_next_state = S_LEN_L;
                    w_cs_add     = 1'b1;
                end
            end
            S_LEN_L: begin
                if (w_accept) begin
                    w_next_state = S_VALIDATE;
                    w_cs_add     = 1'b1;
                end
            end
            S_VALIDATE: begin
                w_next_state = w_bad_frame ? S_ERROR : S_DATA;
            end
            S_DATA: begin
                if (w_accept) begin
                    w_cs_add = 1'b1;
                    if (r_remaining == 16'd1) begin
                        w_next_state = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (w_accept) begin
                    w_next_state = w_csum_ok ? S_DONE : S_ERROR;
                end
            end
            default: w_next_state = S_SYNC;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_in_ready    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= 16'd0;
            r_mem_data    <= 8'd0;
            r_cpu_hold    <= 1'b1;
            r_start_pc    <= DEFAULT_PC;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_addr        <= 16'd0;
            r_len         <= 16'd0;
            r_wr_ptr      <= 16'd0;
            r_remaining   <= 16'd0;
        end else begin
            r_in_ready  <= (w_next_state != S_VALIDATE);
            r_mem_write <= (r_state == S_DATA) && w_accept;
            case (r_state)
                S_SYNC, S_DONE, S_ERROR: begin
                    if (w_accept && w_is_sync) begin
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_cpu_hold <= 1'b1;
                    end
                end
                S_ADDR_H: if (w_accept) r_addr[15:8] <= i_in_byte;
                S_ADDR_L: if (w_accept) r_addr[7:0]  <= i_in_byte;
                S_LEN_H:  if (w_accept) r_len[15:8]  <= i_in_byte;
                S_LEN_L:  if (w_accept) r_len[7:0]   <= i_in_byte;
                S_VALIDATE: begin
                    r_wr_ptr    <= r_addr;
                    r_remaining <= r_len;
                    if (w_bad_frame) begin
                        r_error <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_mem_address <= r_wr_ptr;
                        r_mem_data    <= i_in_byte;
                        r_wr_ptr      <= r_wr_ptr + 16'd1;
                        r_remaining   <= r_remaining - 16'd1;
                    end
                end
                S_CSUM: begin
                    if (w_accept) begin
                        if (w_csum_ok) begin
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                            r_start_pc <= r_addr;
                        end else begin
                            r_error    <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_in_ready    = r_in_ready;
    assign o_mem_write   = r_mem_write;
    assign o_mem_address = r_mem_address;
    assign o_mem_data    = r_mem_data;
    assign o_cpu_hold    = r_cpu_hold;
    assign o_start_pc    = r_start_pc;
    assign o_done        = r_done;
    assign o_error       = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad frames, header rejects, stream gaps and
// mid-frame reset, with every MemWrite pulse captured into a shadow memory.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        o_in_ready;
    logic        o_mem_write;
    logic [15:0] o_mem_address;
    logic [7:0]  o_mem_data;
    logic        o_cpu_hold;
    logic [15:0] o_start_pc;
    logic        o_done;
    logic        o_error;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          gap_mode = 1'b0;
    logic [15:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];
    logic [7:0]  tb_mem[0:127];

    imem_loader #(.MEM_BYTES(128), .DEFAULT_PC(16'd10)) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_in_valid    (in_valid),
        .i_in_byte     (in_byte),
        .o_in_ready    (o_in_ready),
        .o_mem_write   (o_mem_write),
        .o_mem_address (o_mem_address),
        .o_mem_data    (o_mem_data),
        .o_cpu_hold    (o_cpu_hold),
        .o_start_pc    (o_start_pc),
        .o_done        (o_done),
        .o_error       (o_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_mem_write) begin
            wr_addr_q.push_back(o_mem_address);
            wr_data_q.push_back(o_mem_data);
            tb_mem[o_mem_address[6:0]] = o_mem_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear_writes();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        bit moved  = 1'b0;
        if (gap_mode) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_byte  = b;
        while (!moved) begin
            @(negedge clk);
            if (o_in_ready) begin
                @(posedge clk); #1;
                moved = 1'b1;
            end else begin
                waited++;
                if (waited > 50) begin
                    check("ready_timeout", 32'd0, 32'd1);
                    moved = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [15:0] a, input logic [15:0] l);
        send_byte(8'hA5);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        send_byte(l[15:8]);
        send_byte(l[7:0]);
    endtask

    task automatic send_payload4(input logic [31:0] d);
        for (int i = 0; i < 4; i++) send_byte(d[31-8*i -: 8]);
    endtask

    task automatic send_frame4(input logic [15:0] a, input logic [31:0] d, input logic [7:0] cs);
        send_hdr(a, 16'd4);
        check("validate_ready_low", 32'(o_in_ready), 32'd0);
        send_payload4(d);
        send_byte(cs);
    endtask

    task automatic check_writes(input string tag, input logic [15:0] base, input int n,
                                input logic [31:0] d);
        check({tag, "_count"}, 32'(wr_addr_q.size()), 32'(n));
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            check({tag, "_addr"}, 32'(wr_addr_q[i]), 32'(base + 16'(i)));
            check({tag, "_data"}, 32'(wr_data_q[i]), 32'(d[31-8*i -: 8]));
        end
    endtask

    task automatic check_status(input string tag, input logic done, input logic err,
                                input logic hold, input logic [15:0] pc);
        check({tag, "_done"},  32'(o_done),     32'(done));
        check({tag, "_error"}, 32'(o_error),    32'(err));
        check({tag, "_hold"},  32'(o_cpu_hold), 32'(hold));
        check({tag, "_pc"},    32'(o_start_pc), 32'(pc));
    endtask

    logic [15:0] bad_addr[3] = '{16'h007E, 16'h000B, 16'h0010};
    logic [15:0] bad_len[3]  = '{16'h0004, 16'h0002, 16'h0003};

    initial begin
        for (int i = 0; i < 128; i++) tb_mem[i] = 8'h00;

        // reset values
        #12;
        check("rst_ready", 32'(o_in_ready), 32'd0);
        check("rst_memwrite", 32'(o_mem_write), 32'd0);
        check("rst_memaddr", 32'(o_mem_address), 32'd0);
        check("rst_memdata", 32'(o_mem_data), 32'd0);
        check_status("rst", 1'b0, 1'b0, 1'b1, 16'h000A);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", 32'(o_in_ready), 32'd1);

        // good frame
        clear_writes();
        send_frame4(16'h000A, 32'h12345678, 8'h22);
        check_writes("good1", 16'h000A, 4, 32'h12345678);
        check_status("good1", 1'b1, 1'b0, 1'b0, 16'h000A);

        // bad checksum, then recovery
        clear_writes();
        send_frame4(16'h000A, 32'h12345678, 8'h23);
        check_writes("badcs", 16'h000A, 4, 32'h12345678);
        check_status("badcs", 1'b0, 1'b1, 1'b1, 16'h000A);
        clear_writes();
        send_frame4(16'h000A, 32'h12345678, 8'h22);
        check_writes("resend", 16'h000A, 4, 32'h12345678);
        check_status("resend", 1'b1, 1'b0, 1'b0, 16'h000A);

        // header rejects: bounds, odd addr, odd len
        for (int k = 0; k < 3; k++) begin
            clear_writes();
            send_hdr(bad_addr[k], bad_len[k]);
            check("rej_validate_ready", 32'(o_in_ready), 32'd0);
            @(posedge clk); #1;
            check("rej_ready_back", 32'(o_in_ready), 32'd1);
            check_status("rej", 1'b0, 1'b1, 1'b1, 16'h000A);
            @(posedge clk); #1;
            check("rej_no_writes", 32'(wr_addr_q.size()), 32'd0);
        end
        clear_writes();
        send_frame4(16'h000A, 32'h12345678, 8'h22);
        check_writes("after_rej", 16'h000A, 4, 32'h12345678);
        check_status("after_rej", 1'b1, 1'b0, 1'b0, 16'h000A);

        // garbage and InValid gaps
        gap_mode = 1'b1;
        clear_writes();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        check("garbage_no_writes", 32'(wr_addr_q.size()), 32'd0);
        send_frame4(16'h000A, 32'h12345678, 8'h22);
        check_writes("gap", 16'h000A, 4, 32'h12345678);
        check_status("gap", 1'b1, 1'b0, 1'b0, 16'h000A);
        gap_mode = 1'b0;

        // reload at 0x0030 while running
        clear_writes();
        check("reload_hold_before", 32'(o_cpu_hold), 32'd0);
        send_byte(8'hA5);
        check("reload_hold_rise", 32'(o_cpu_hold), 32'd1);
        check("reload_done_clr", 32'(o_done), 32'd0);
        send_byte(8'h00);
        send_byte(8'h30);
        send_byte(8'h00);
        send_byte(8'h04);
        send_payload4(32'h11223344);
        check("reload_hold_mid", 32'(o_cpu_hold), 32'd1);
        send_byte(8'hDE);
        check_writes("reload", 16'h0030, 4, 32'h11223344);
        check_status("reload", 1'b1, 1'b0, 1'b0, 16'h0030);

        // reset mid-frame
        clear_writes();
        send_hdr(16'h0020, 16'h0004);
        send_byte(8'hAA);
        send_byte(8'hBB);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_ready", 32'(o_in_ready), 32'd0);
        check_status("midrst", 1'b0, 1'b0, 1'b1, 16'h000A);
        @(posedge clk); #1;
        check("midrst_ready_hold", 32'(o_in_ready), 32'd0);
        check("midrst_memwrite", 32'(o_mem_write), 32'd0);
        @(negedge clk); rst = 1'b0;
        check("midrst_count", 32'(wr_addr_q.size()), 32'd2);
        check("midrst_mem20", 32'(tb_mem[7'h20]), 32'hAA);
        check("midrst_mem21", 32'(tb_mem[7'h21]), 32'hBB);
        check("midrst_mem22", 32'(tb_mem[7'h22]), 32'h00);
        @(posedge clk); #1;
        check("midrst_ready_back", 32'(o_in_ready), 32'd1);
        clear_writes();
        send_frame4(16'h000A, 32'h12345678, 8'h22);
        check_writes("post_rst", 16'h000A, 4, 32'h12345678);
        check_status("post_rst", 1'b1, 1'b0, 1'b0, 16'h000A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader: writer side of the CPU's byte-wide, big-endian instruction memory.
- Receives a framed image over a valid/ready byte interface and writes it into instruction memory one byte per cycle.
- Holds the CPU until a frame with a good checksum completes, then releases it with the start PC.
- Sits between the host/testbench byte source and the CPU/instruction-memory pair.

Parameters:
MEM_BYTES, 128, instruction memory size in bytes; legal byte addresses are 0..MEM_BYTES-1
DEFAULT_PC, 16'd10, StartPC value after reset and until the first successful load

Ports:
Clock  in  1  single system clock; all state updates on posedge
Reset  in  1  asynchronous, active-high reset
InValid  in  1  source has a byte on InByte
InByte  in  8  stream byte
InReady  out  1  loader accepts a byte; transfer occurs on posedge when InValid & InReady
MemWrite  out  1  one-cycle byte write strobe to instruction memory
MemAddress  out  16  byte address for MemWrite
MemData  out  8  byte data for MemWrite
CpuHold  out  1  1 = CPU must not fetch or advance its PC
StartPC  out  16  PC the CPU loads when CpuHold falls
Done  out  1  level; last frame loaded and checksum verified
Error  out  1  level; last frame rejected

Behaviour:
- Frame format: A5, addr_hi, addr_lo, len_hi, len_lo, len payload bytes, csum.
  - csum = 8-bit sum mod 256 of addr_hi, addr_lo, len_hi, len_lo and all payload bytes.
- States: SYNC, ADDR_H, ADDR_L, LEN_H, LEN_L, VALIDATE, DATA, CSUM, DONE, ERROR.
- Reset (async) values: state SYNC, InReady 0, MemWrite 0, MemAddress 0, MemData 0, CpuHold 1, StartPC DEFAULT_PC, Done 0, Error 0.
- InReady is registered. It is 1 in every state except VALIDATE, and it rises on the first posedge after Reset deasserts.
- SYNC: accepted byte A5 goes to ADDR_H; any other accepted byte is discarded.
- ADDR_H/ADDR_L/LEN_H/LEN_L: each accepted byte is latched and the state advances; the checksum accumulator is cleared on A5 and adds each of these bytes.
- VALIDATE: exactly one cycle with InReady=0, no byte accepted. Goes to ERROR if any of the following holds, otherwise to DATA:
  - len == 0
  - len odd
  - addr odd
  - addr+len > MEM_BYTES, computed at 17 bits so no wrap-around
- DATA: each accepted byte produces MemWrite=1 for exactly one cycle, on the cycle after acceptance, with MemAddress = addr + index and MemData = the byte.
  - Index 0 goes to addr, so the first byte of each instruction lands at the even address (big-endian).
  - Each byte is added to the checksum.
  - A remaining-byte counter moves to CSUM when it reaches 0.
- CSUM: on the accepted byte, go to DONE if byte == accumulator, else go to ERROR. Same edge, no extra cycle.
- DONE: Done=1, Error=0, CpuHold=0, StartPC=addr (updated on DONE entry).
- ERROR: Error=1, Done=0, CpuHold=1, StartPC unchanged.
  - Bytes already written stay in memory; there is no rollback.
- DONE/ERROR: an accepted A5 starts a new frame (→ADDR_H) and clears Done/Error. CpuHold rises on that same edge. Other bytes are ignored.
- Gaps in InValid in any state: state, counters and checksum hold.
- Reset mid-frame: immediate return to reset values. Partially written bytes remain in memory; StartPC returns to DEFAULT_PC.
- MemWrite never asserts outside the cycle following a DATA-state acceptance.

Decomposition:
- Shared package holds:
  - the state enumeration
  - SYNC_BYTE = 8'hA5
  - DEFAULT_PC = 16'd10 (same start address the datapath uses at power-up)
- One sub-module: frame_checksum, an 8-bit accumulator with clear and add-enable inputs and a sum output.

Test Plan:
- Reset, then A5 00 0A 00 04 12 34 56 78 22 -> MemWrite pulses at 000A/000B/000C/000D with data 12/34/56/78; Done=1, Error=0, CpuHold=0, StartPC=000A.
- Same frame with csum 23 -> four writes still occur; Error=1, CpuHold=1, StartPC=000A (default); resending the good frame -> Done=1.
- Frame A5 00 7E 00 04 (bounds), A5 00 0B 00 02 (odd addr), or A5 00 10 00 03 (odd len) -> InReady low one cycle, then Error=1, zero MemWrite pulses; a following good frame loads correctly.
- Garbage 00 FF 5A before a good frame, with InValid toggling every other cycle -> garbage ignored, identical writes and Done as the first scenario.
- Frame A5 00 20 00 04 AA BB, then Reset pulse -> CpuHold=1, Done=0, StartPC=000A, InReady 0 during reset; bytes 0020=AA and 0021=BB remain written.
- After Done, new good frame at 0x0030 -> CpuHold rises on the A5 acceptance and falls at its csum; StartPC=0030.
